// File: rtl/jk_edge_driver_if.sv
// rtl/jk_edge_driver_if.sv - raw request inputs and JK command outputs of jk_edge_driver
interface jk_edge_driver_if;
  logic       set_in;
  logic       clr_in;
  logic       tog_in;
  logic       J;
  logic       K;
  logic       E;
  logic [2:0] stable;
  logic [7:0] cmd_count;

  // Side that drives the raw requests and observes the JK commands
  modport master (
    output set_in,
    output clr_in,
    output tog_in,
    input  J,
    input  K,
    input  E,
    input  stable,
    input  cmd_count
  );

  // The driver itself
  modport slave (
    input  set_in,
    input  clr_in,
    input  tog_in,
    output J,
    output K,
    output E,
    output stable,
    output cmd_count
  );
endinterface

// File: rtl/jk_edge_driver.sv
// rtl/jk_edge_driver.sv - debounced set/clr/tog requests turned into JK flip-flop command strobes
module jk_edge_driver #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic           clock,
  input  logic           reset,
  jk_edge_driver_if.slave bus
);

  // Channel order everywhere is {tog, clr, set}, bit 0 = set.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [2:0]            sync1_q,  sync1_d;
  logic [2:0]            sync2_q,  sync2_d;
  logic [2:0]            stable_q, stable_d;
  logic [2:0][CNT_W-1:0] cnt_q,    cnt_d;
  // Channels whose stable level rose on the previous edge; the strobe follows one edge later.
  logic [2:0]            rise_q,   rise_d;
  logic                  e_q,      e_d;
  logic                  j_q,      j_d;
  logic                  k_q,      k_d;
  logic [7:0]            cmd_count_q, cmd_count_d;

  // Synchronise, debounce each channel, detect stable rises and build the merged JK strobe
  always_comb begin
    sync1_d     = {bus.tog_in, bus.clr_in, bus.set_in};
    sync2_d     = sync1_q;
    stable_d    = stable_q;
    cnt_d       = cnt_q;

    for (int ch = 0; ch < 3; ch++) begin
      if (sync2_q[ch] != stable_q[ch]) begin
        if (cnt_q[ch] == CNT_MAX) begin
          stable_d[ch] = sync2_q[ch];
          cnt_d[ch]    = '0;
        end else begin
          cnt_d[ch]    = cnt_q[ch] + CNT_W'(1);
        end
      end else begin
        cnt_d[ch] = '0;
      end
    end

    // Only 0->1 stable transitions count as events; falling edges are silent.
    rise_d      = stable_d & ~stable_q;

    // set+clr or anything with tog merges into J=K=1 (toggle).
    e_d         = |rise_q;
    j_d         = rise_q[0] | rise_q[2];
    k_d         = rise_q[1] | rise_q[2];
    cmd_count_d = cmd_count_q + {7'b0, e_d};
  end

  // State register; reset wins over any transition or strobe due on the same edge
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      stable_q    <= '0;
      cnt_q       <= '0;
      rise_q      <= '0;
      e_q         <= 1'b0;
      j_q         <= 1'b0;
      k_q         <= 1'b0;
      cmd_count_q <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      stable_q    <= stable_d;
      cnt_q       <= cnt_d;
      rise_q      <= rise_d;
      e_q         <= e_d;
      j_q         <= j_d;
      k_q         <= k_d;
      cmd_count_q <= cmd_count_d;
    end
  end

  assign bus.J         = j_q;
  assign bus.K         = k_q;
  assign bus.E         = e_q;
  assign bus.stable    = stable_q;
  assign bus.cmd_count = cmd_count_q;

endmodule

// File: tb/tb_jk_edge_driver.sv
// tb/tb_jk_edge_driver.sv - scoreboard bench for jk_edge_driver
module tb_jk_edge_driver;

  localparam int DC  = 4;
  localparam int LAT = 3 + DC;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  typedef struct {
    logic       j;
    logic       k;
    logic [7:0] cnt;
    int         at;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] exp_cnt = 8'd0;

  jk_edge_driver_if bus ();

  jk_edge_driver #(.DEBOUNCE_CYCLES(DC), .CNT_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  // Posedge counter: after posedge n, cyc == n
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_strobe(input logic j, input logic k, input int at);
    exp_t e;
    exp_cnt = exp_cnt + 8'd1;
    e.j   = j;
    e.k   = k;
    e.cnt = exp_cnt;
    e.at  = at;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Monitor: every observed strobe must match the head of the scoreboard
  always @(negedge clock) begin
    if (!reset && bus.E) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_strobe: got E=1 J=%0b K=%0b cnt=%0d at cycle %0d, expected no strobe",
                 bus.J, bus.K, bus.cmd_count, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.J !== e.j || bus.K !== e.k || bus.cmd_count !== e.cnt || cyc != e.at) begin
          fails++;
          $display("FAIL strobe: got J=%0b K=%0b cnt=%0d cycle=%0d expected J=%0b K=%0b cnt=%0d cycle=%0d",
                   bus.J, bus.K, bus.cmd_count, cyc, e.j, e.k, e.cnt, e.at);
        end
      end
    end
  end

  initial begin
    int c;
    bus.set_in = 1'b0;
    bus.clr_in = 1'b0;
    bus.tog_in = 1'b0;

    // Reset state
    idle(3);
    check("reset_E", int'(bus.E), 0);
    check("reset_J", int'(bus.J), 0);
    check("reset_K", int'(bus.K), 0);
    check("reset_stable", int'(bus.stable), 0);
    check("reset_cmd_count", int'(bus.cmd_count), 0);
    reset = 1'b0;
    idle(2);

    // Single set: stable at edge 6, strobe after edge 7
    c = cyc;
    bus.set_in = 1'b1;
    push_strobe(1'b1, 1'b0, c + LAT);
    idle(2 + DC - 1);
    check("set_stable_before", int'(bus.stable), 0);
    idle(1);
    check("set_stable_at_edge6", int'(bus.stable), 1);
    idle(4);
    check("set_cmd_count", int'(bus.cmd_count), 1);
    bus.set_in = 1'b0;
    idle(LAT + 3);
    check("set_release_stable", int'(bus.stable), 0);

    // Short clr glitch: 3 samples, no change
    bus.clr_in = 1'b1;
    idle(3);
    bus.clr_in = 1'b0;
    idle(12);
    check("glitch_stable", int'(bus.stable), 0);
    check("glitch_cmd_count", int'(bus.cmd_count), 1);

    // set and clr together -> one toggle strobe
    c = cyc;
    bus.set_in = 1'b1;
    bus.clr_in = 1'b1;
    push_strobe(1'b1, 1'b1, c + LAT);
    idle(LAT + 2);
    check("setclr_stable", int'(bus.stable), 3);
    bus.set_in = 1'b0;
    bus.clr_in = 1'b0;
    idle(LAT + 3);

    // set, then tog one cycle later -> consecutive strobes
    c = cyc;
    bus.set_in = 1'b1;
    push_strobe(1'b1, 1'b0, c + LAT);
    idle(1);
    bus.tog_in = 1'b1;
    push_strobe(1'b1, 1'b1, c + 1 + LAT);
    idle(LAT + 3);
    check("settog_cmd_count", int'(bus.cmd_count), 4);
    bus.set_in = 1'b0;
    bus.tog_in = 1'b0;
    idle(LAT + 3);

    // Reset lands on the edge the clr strobe is due; held clr produces a fresh strobe
    c = cyc;
    bus.clr_in = 1'b1;
    idle(LAT - 1);
    reset = 1'b1;
    idle(1);
    check("rst_drop_E", int'(bus.E), 0);
    check("rst_drop_J", int'(bus.J), 0);
    check("rst_drop_K", int'(bus.K), 0);
    check("rst_drop_cmd_count", int'(bus.cmd_count), 0);
    reset = 1'b0;
    exp_cnt = 8'd0;
    c = cyc;
    push_strobe(1'b0, 1'b1, c + LAT);
    idle(LAT + 2);
    check("rst_fresh_cmd_count", int'(bus.cmd_count), 1);
    bus.clr_in = 1'b0;
    idle(LAT + 3);

    // 256 set/release cycles: count wraps to 0, falling edges silent
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    exp_cnt = 8'd0;
    idle(2);
    for (int i = 0; i < 256; i++) begin
      c = cyc;
      bus.set_in = 1'b1;
      push_strobe(1'b1, 1'b0, c + LAT);
      idle(LAT + 1);
      bus.set_in = 1'b0;
      idle(LAT + 1);
    end
    idle(4);
    check("wrap_cmd_count", int'(bus.cmd_count), 0);
    check("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
